// File: rtl/serial_pattern_tx_if.sv
// rtl/serial_pattern_tx_if.sv - word-load / serial-output bundle for serial_pattern_tx
interface serial_pattern_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             SO;
    logic             busy;
    logic             done;

    modport master (
        output din,
        output load,
        input  ready,
        input  SO,
        input  busy,
        input  done
    );

    modport slave (
        input  din,
        input  load,
        output ready,
        output SO,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - LSB-first word serializer; optional 1,1,1 preamble via SERIAL_PATTERN_TX_PREAMBLE_EN
module serial_pattern_tx #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    serial_pattern_tx_if.slave bus
);
    // Counter also has to reach 2 for the preamble, hence the 2-bit floor.
    localparam int CNT_W = (WIDTH < 4) ? 2 : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(2);
    typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, DATA = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd2} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             so_q, so_d;
    logic             last_bit;
    logic             ready_w;
    logic             accept;

    // The state always describes what so_q is currently presenting.
    assign last_bit = (state_q == DATA) && (cnt_q == LAST_BIT);
    assign ready_w  = !rst && ((state_q == IDLE) || last_bit);
    assign accept   = bus.load && ready_w;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        so_d    = so_q;

        case (state_q)
            IDLE: begin
                so_d = 1'b0;
            end
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
            PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = DATA;
                    so_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    cnt_d   = '0;
                end else begin
                    so_d  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            DATA: begin
                if (!last_bit) begin
                    so_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    state_d = IDLE;
                    so_d    = 1'b0;
                    shreg_d = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                so_d    = 1'b0;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            cnt_d = '0;
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
            state_d = PRE;
            so_d    = 1'b1;
            shreg_d = bus.din;
`else
            state_d = DATA;
            so_d    = bus.din[0];
            shreg_d = bus.din >> 1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            so_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            so_q    <= so_d;
        end
    end

    assign bus.ready = ready_w;
    assign bus.SO    = so_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = last_bit;
endmodule

// File: doc/serial_pattern_tx.md
SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data word length in bits; the legal range is 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port din, input, WIDTH bits: the parallel word to transmit.
REQ-005 The block SHALL have port load, input, 1 bit: word-valid request.
REQ-006 The block SHALL have port ready, output, 1 bit: high when a load will be accepted this cycle.
REQ-007 The block SHALL have port SO, output, 1 bit: the serial data output, registered.
REQ-008 The block SHALL have port busy, output, 1 bit: high while preamble or data bits are on SO.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse coincident with the last data bit on SO.

Function
REQ-010 The block SHALL accept a word when load and ready are both high at a rising edge, capturing din into an internal shift register.
REQ-011 The block SHALL drive data LSB-first, so that a right-shifting receiver (serial input into its MSB) holds din in original bit order after WIDTH shifts.
REQ-012 The block SHALL implement a state machine with states IDLE, PRE and DATA.
REQ-013 IDLE SHALL go to PRE on accept when PREAMBLE_EN is defined, otherwise to DATA.
REQ-014 PRE SHALL go to DATA after its last preamble bit.
REQ-015 DATA SHALL go to IDLE after bit WIDTH-1, or to PRE/DATA directly on a back-to-back accept.
REQ-016 The first transmitted bit SHALL appear on SO in the cycle immediately after the accepting edge, giving a latency of 1 clock.
REQ-017 Each bit SHALL be held on SO for exactly one clock, with no gaps between preamble and data bits.
REQ-018 SO SHALL be 0 in IDLE, and busy SHALL be 0 in IDLE.
REQ-019 ready SHALL be high in IDLE and during the last DATA bit, and low otherwise.
REQ-020 A load asserted while ready is low SHALL be ignored, with no queuing and no effect on the current word.
REQ-021 On a back-to-back accept during the last DATA bit, the next word's first bit SHALL follow with no idle cycle, and busy SHALL stay high.
REQ-022 A bit counter SHALL be wide enough for WIDTH-1 and SHALL never wrap mid-word.
REQ-023 done SHALL be high only during bit WIDTH-1 of DATA, including on back-to-back transfers.

Reset
REQ-024 When rst is high at a rising edge, the block SHALL force state IDLE, SO=0, busy=0, done=0 and clear the shift register and counter.
REQ-025 ready SHALL be 0 while rst is high and SHALL be 1 from the first cycle after rst is released.
REQ-026 A reset asserted mid-word SHALL abort the transfer immediately; no remaining bits are sent and no done pulse is produced.
REQ-027 If load and rst are high in the same cycle, rst SHALL win and the word SHALL be discarded.

Configuration
REQ-028 When macro SERIAL_PATTERN_TX_PREAMBLE_EN is defined, each word SHALL be preceded by a 3-bit preamble of 1,1,1 in the PRE state, and busy SHALL cover the preamble.
REQ-029 When the macro is undefined, the PRE state and its logic SHALL be absent, and data SHALL start 1 cycle after accept.

Verification
REQ-030 Basic word (WIDTH=4, no preamble): reset, then accept din=4'b1011 -> SO=1,1,0,1 on the next 4 cycles, done high on the 4th, then SO=0 and ready=1.
REQ-031 Preamble (macro defined): accept din=4'b1011 -> SO=1,1,1,1,1,0,1 over 7 cycles, and busy high for exactly those 7 cycles.
REQ-032 Back-to-back: accept 4'b0111, then assert load with 4'b1110 during the last bit -> SO=1,1,1,0,0,1,1,1 with no gap and two done pulses, 4 cycles apart.
REQ-033 Load while busy: pulse load with din=4'hF in bit 1 of 4'b0001 -> output stays 1,0,0,0 and the 4'hF word is never sent.
REQ-034 Reset mid-word: assert rst after 2 bits of 4'b1111 -> SO=0, busy=0, done never pulses, and ready=1 on the cycle after rst is released.
REQ-035 Load and rst together: assert both with din=4'b1010 -> nothing is transmitted, and a later accept of 4'b0011 sends 1,1,0,0.
